// File: rtl/display_scroller.sv
// Scrolling message sequencer for the four-digit seven-segment driver.
// Build option: define SCROLL_LOOP_EN to honour the loop input (otherwise every scroll is one-shot).
module display_scroller #(
  parameter int MSG_DEPTH = 16,
  parameter int TICK_DIV  = 12500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [7:0] wr_char,
  input  logic       wr_last,
  input  logic       start,
  input  logic       abort,
  input  logic       loop,
  output logic [7:0] display_0,
  output logic [7:0] display_1,
  output logic [7:0] display_2,
  output logic [7:0] display_3,
  output logic       busy,
  output logic       done
);

  localparam int LW = $clog2(MSG_DEPTH + 1);
  localparam int WW = $clog2(MSG_DEPTH + 4);
  localparam int PW = WW + 1;
  localparam int AW = $clog2(MSG_DEPTH);
  localparam int TW = 24;
  localparam logic [7:0] BLANK = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_SCROLL = 2'd2
  } state_t;

  state_t        state_r;
  logic [7:0]    msg_r [MSG_DEPTH];
  logic [7:0]    disp_r [4];
  logic [LW-1:0] len_r;
  logic [WW-1:0] w_r;
  logic [TW-1:0] tick_r;
  logic          wr_ready_r;
  logic          busy_r;
  logic          done_r;

  logic          wr_fire_s;
  logic          tick_last_s;
  logic          frame_end_s;
  logic          loop_en_s;
  logic [WW-1:0] w_adv_s;
  logic [LW-1:0] len_inc_s;

  // Character shown at digit k for frame w: buffer slot w+k-4 when it lies inside the message.
  function automatic logic [7:0] frame_char(input logic [WW-1:0] w, input int k);
    logic [PW-1:0] pos;
    logic [PW-1:0] off;
    pos = PW'(w) + PW'(k);
    off = pos - PW'(4);
    if ((pos >= PW'(4)) && (pos < (PW'(len_r) + PW'(4)))) begin
      return msg_r[off[AW-1:0]];
    end else begin
      return BLANK;
    end
  endfunction

  assign wr_fire_s   = wr_valid && wr_ready_r && (state_r == ST_IDLE) && !abort;
  assign tick_last_s = (tick_r == TW'(TICK_DIV - 1));
  assign frame_end_s = (w_r == (WW'(len_r) + WW'(3)));
  assign w_adv_s     = w_r + WW'(1);
  assign len_inc_s   = len_r + LW'(1);

`ifdef SCROLL_LOOP_EN
  // Loop request is only meaningful when the looping build option is present.
  always_comb begin
    loop_en_s = loop;
  end
`else
  logic unused_loop_s;
  assign unused_loop_s = loop;

  // Looping is compiled out: every scroll ends after one pass.
  always_comb begin
    loop_en_s = 1'b0;
  end
`endif

  // Message buffer storage; contents need no reset since len bounds every read.
  always_ff @(posedge clk) begin
    if (!rst && wr_fire_s) begin
      msg_r[len_r[AW-1:0]] <= wr_char;
    end
  end

  // Sequencer FSM with registered display, handshake and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      len_r      <= '0;
      w_r        <= '0;
      tick_r     <= '0;
      wr_ready_r <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      for (int k = 0; k < 4; k++) disp_r[k] <= BLANK;
    end else if (abort) begin
      // Abort outranks start, tick and any write presented in the same cycle.
      state_r    <= ST_IDLE;
      len_r      <= '0;
      w_r        <= '0;
      tick_r     <= '0;
      wr_ready_r <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      for (int k = 0; k < 4; k++) disp_r[k] <= BLANK;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          wr_ready_r <= 1'b1;
          if (wr_fire_s) begin
            len_r <= len_inc_s;
            if (wr_last || (len_inc_s == LW'(MSG_DEPTH))) begin
              state_r    <= ST_ARMED;
              wr_ready_r <= 1'b0;
            end
          end
        end
        ST_ARMED: begin
          wr_ready_r <= 1'b0;
          if (start) begin
            state_r <= ST_SCROLL;
            w_r     <= '0;
            tick_r  <= '0;
            busy_r  <= 1'b1;
            for (int k = 0; k < 4; k++) disp_r[k] <= BLANK;
          end
        end
        ST_SCROLL: begin
          wr_ready_r <= 1'b0;
          if (tick_last_s) begin
            tick_r <= '0;
            if (frame_end_s) begin
              w_r <= '0;
              for (int k = 0; k < 4; k++) disp_r[k] <= BLANK;
              if (!loop_en_s) begin
                state_r <= ST_ARMED;
                busy_r  <= 1'b0;
                done_r  <= 1'b1;
              end
            end else begin
              w_r <= w_adv_s;
              for (int k = 0; k < 4; k++) disp_r[k] <= frame_char(w_adv_s, k);
            end
          end else begin
            tick_r <= tick_r + TW'(1);
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          len_r      <= '0;
          w_r        <= '0;
          tick_r     <= '0;
          wr_ready_r <= 1'b1;
          busy_r     <= 1'b0;
          for (int k = 0; k < 4; k++) disp_r[k] <= BLANK;
        end
      endcase
    end
  end

  assign display_0 = disp_r[0];
  assign display_1 = disp_r[1];
  assign display_2 = disp_r[2];
  assign display_3 = disp_r[3];
  assign wr_ready  = wr_ready_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_display_scroller.sv
// Scoreboard bench for display_scroller: stimulus queues expected output snapshots,
// a monitor pops one on every change of the observed outputs and checks value and hold time.
module tb_display_scroller;

  localparam int DEPTH = 16;
  localparam int TDIV  = 4;
  localparam logic [31:0] BL = 32'h20202020;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_char;
  logic       wr_last;
  logic       start;
  logic       abort;
  logic       loop;
  logic [7:0] display_0, display_1, display_2, display_3;
  logic       busy;
  logic       done;

  typedef struct packed {
    logic [7:0] d0, d1, d2, d3;
    logic       busy;
    logic       done;
    logic       rdy;
  } obs_t;

  typedef struct {
    obs_t v;
    int   dur;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  bit   mon_en = 1'b0;

  display_scroller #(.MSG_DEPTH(DEPTH), .TICK_DIV(TDIV)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_char(wr_char), .wr_last(wr_last),
    .start(start), .abort(abort), .loop(loop),
    .display_0(display_0), .display_1(display_1), .display_2(display_2), .display_3(display_3),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(input logic [31:0] d, input logic b, input logic dn, input logic r);
    return {d, b, dn, r};
  endfunction

  function automatic obs_t fr(input logic [31:0] d);
    return mk(d, 1'b1, 1'b0, 1'b0);
  endfunction

  // Expected frame for a 16-char message "A".."P" at frame index w.
  function automatic logic [31:0] full_frame(input int w);
    logic [31:0] d;
    int p;
    d = 32'h0;
    for (int k = 0; k < 4; k++) begin
      p = w + k - 4;
      d = {d[23:0], ((p >= 0) && (p < DEPTH)) ? (8'h41 + 8'(p)) : 8'h20};
    end
    return d;
  endfunction

  task automatic push(input obs_t v, input int dur);
    exp_t e;
    e.v = v;
    e.dur = dur;
    sb_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_char(input logic [7:0] c, input logic last);
    wr_valid = 1'b1;
    wr_char  = c;
    wr_last  = last;
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
  endtask

  task automatic push_hello();
    push(fr(BL), 0);
    push(fr(32'h20202048), TDIV);
    push(fr(32'h20204845), TDIV);
    push(fr(32'h2048454C), TDIV);
    push(fr(32'h48454C4C), TDIV);
    push(fr(32'h454C4C4F), TDIV);
    push(fr(32'h4C4C4F20), TDIV);
    push(fr(32'h4C4F2020), TDIV);
    push(fr(32'h4F202020), TDIV);
    push(mk(BL, 1'b0, 1'b1, 1'b0), TDIV);
    push(mk(BL, 1'b0, 1'b0, 1'b0), 1);
  endtask

  task automatic wait_drain(input int limit, input string name);
    for (int i = 0; i < limit && sb_q.size() != 0; i++) @(posedge clk);
    #1;
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL drain_%s: %0d expected snapshots never seen, required 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  // Monitor: every change of the observed outputs consumes one expected snapshot.
  initial begin
    obs_t prev, cur;
    exp_t e;
    int run;
    prev = 'x;
    run = 0;
    wait (mon_en);
    forever begin
      @(negedge clk);
      cur = {display_0, display_1, display_2, display_3, busy, done, wr_ready};
      if (cur !== prev) begin
        tests++;
        if (sb_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_change: got %h, required no change", cur);
        end else begin
          e = sb_q.pop_front();
          if (cur !== e.v) begin
            fails++;
            $display("FAIL snapshot: got %h, required %h", cur, e.v);
          end
          if (e.dur != 0) begin
            tests++;
            if (run + 1 != e.dur) begin
              fails++;
              $display("FAIL hold_cycles: got %0d, required %0d (snapshot %h)", run + 1, e.dur, e.v);
            end
          end
        end
        run = 0;
        prev = cur;
      end else begin
        run++;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_char = 8'h00; wr_last = 1'b0;
    start = 1'b0; abort = 1'b0; loop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    push(mk(BL, 1'b0, 1'b0, 1'b1), 0);
    mon_en = 1'b1;
    tick(2);
    wait_drain(10, "reset");

    // HELLO one-shot scroll
    push(mk(BL, 1'b0, 1'b0, 1'b0), 0);
    write_char(8'h48, 1'b0);
    write_char(8'h45, 1'b0);
    write_char(8'h4C, 1'b0);
    write_char(8'h4C, 1'b0);
    write_char(8'h4F, 1'b1);
    tick(2);
    push_hello();
    pulse_start();
    wait_drain(100, "hello");

    // Replay from ARMED after done
    tick(2);
    push_hello();
    pulse_start();
    wait_drain(100, "replay");

    // Abort on the same edge as the second frame tick; later start ignored
    tick(2);
    push(fr(BL), 0);
    push(fr(32'h20202048), TDIV);
    push(mk(BL, 1'b0, 1'b0, 1'b1), TDIV);
    pulse_start();
    repeat (7) @(posedge clk);
    #1;
    pulse_abort();
    tick(2);
    pulse_start();
    tick(4);
    wait_drain(20, "abort");

    // One-char message after abort proves len restarted at 0
    push(mk(BL, 1'b0, 1'b0, 1'b0), 0);
    write_char(8'h5A, 1'b1);
    tick(1);
    push(fr(BL), 0);
    push(fr(32'h2020205A), TDIV);
    push(fr(32'h20205A20), TDIV);
    push(fr(32'h205A2020), TDIV);
    push(fr(32'h5A202020), TDIV);
    push(mk(BL, 1'b0, 1'b1, 1'b0), TDIV);
    push(mk(BL, 1'b0, 1'b0, 1'b0), 1);
    pulse_start();
    wait_drain(60, "single_char");

    // Full buffer: 16 writes without wr_last, then a refused 17th
    push(mk(BL, 1'b0, 1'b0, 1'b1), 0);
    pulse_abort();
    push(mk(BL, 1'b0, 1'b0, 1'b0), 0);
    for (int i = 0; i < DEPTH; i++) write_char(8'h41 + 8'(i), 1'b0);
    write_char(8'h51, 1'b1);
    tick(1);
    push(fr(BL), 0);
    for (int w = 1; w < DEPTH + 4; w++) push(fr(full_frame(w)), TDIV);
    push(mk(BL, 1'b0, 1'b1, 1'b0), TDIV);
    push(mk(BL, 1'b0, 1'b0, 1'b0), 1);
    pulse_start();
    wait_drain(150, "full_buffer");

    // Loop: "AB" wraps while loop=1, ends with done once loop drops
    push(mk(BL, 1'b0, 1'b0, 1'b1), 0);
    pulse_abort();
    push(mk(BL, 1'b0, 1'b0, 1'b0), 0);
    write_char(8'h41, 1'b0);
    write_char(8'h42, 1'b1);
    tick(1);
    loop = 1'b1;
    push(fr(BL), 0);
`ifdef SCROLL_LOOP_EN
    for (int pass = 0; pass < 4; pass++) begin
      if (pass != 0) push(fr(BL), TDIV);
`else
    begin
`endif
      push(fr(32'h20202041), TDIV);
      push(fr(32'h20204142), TDIV);
      push(fr(32'h20414220), TDIV);
      push(fr(32'h41422020), TDIV);
      push(fr(32'h42202020), TDIV);
    end
    push(mk(BL, 1'b0, 1'b1, 1'b0), TDIV);
    push(mk(BL, 1'b0, 1'b0, 1'b0), 1);
    pulse_start();
    repeat (83) @(posedge clk);
    #1;
    loop = 1'b0;
    wait_drain(200, "loop");

    // Reset mid-scroll, then start must be ignored in IDLE
    tick(2);
    push(fr(BL), 0);
    push(fr(32'h20202041), TDIV);
    push(fr(32'h20204142), TDIV);
    push(mk(BL, 1'b0, 1'b0, 1'b1), 3);
    pulse_start();
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    pulse_start();
    tick(4);
    wait_drain(20, "mid_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
